// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit BCD stopwatch / preset-timer path.
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [DIGIT_W-1:0] clampDigit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic [6:0] bcdValue(input logic [DIGIT_W-1:0] t, input logic [DIGIT_W-1:0] o);
        return 7'(t) * 7'd10 + 7'(o);
    endfunction

endpackage

// File: rtl/seg_timer_ctrl_key_edge.sv
// Two-flop synchroniser plus falling-edge detector for one active-low push key.
module key_edge (
    input  logic clk_out,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic [2:0] r_valid;

    // r_valid blanks presses until the pipeline holds only real pin samples,
    // so a key held through reset must be released before it counts again.
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_valid <= 3'b000;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= {r_valid[1:0], 1'b1};
        end
    end

    assign o_press = r_valid[2] & r_prev & ~r_sync2;

endmodule

// File: rtl/seg_timer_ctrl.sv
// Two-digit BCD stopwatch / preset down-timer feeding the seven-segment decoder.
module seg_timer_ctrl
    import seg_pkg::*;
#(
    parameter int MAX_TENS  = 9,
    parameter int MAX_ONES  = 9,
    parameter int BLINK_DIV = 4
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       mode,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] seg_data_1,
    output logic [3:0] seg_data_2,
    output logic [1:0] state,
    output logic       done,
    output logic       blink
);

    localparam logic [DIGIT_W-1:0] LIM_TENS = DIGIT_W'(MAX_TENS);
    localparam logic [DIGIT_W-1:0] LIM_ONES = DIGIT_W'(MAX_ONES);
    localparam logic [6:0]         LIMIT    = 7'(MAX_TENS * 10 + MAX_ONES);
    localparam int                 CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_DIV - 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [DIGIT_W-1:0]   r_tens;
    logic [DIGIT_W-1:0]   r_ones;
    logic                 r_mode;
    logic                 r_blink;
    logic [CNT_W-1:0]     r_blinkCnt;

    logic                 w_startPress;
    logic                 w_clearPress;
    logic [DIGIT_W-1:0]   w_presetTens;
    logic [DIGIT_W-1:0]   w_presetOnes;
    logic [DIGIT_W-1:0]   w_loadTens;
    logic [DIGIT_W-1:0]   w_loadOnes;
    logic [DIGIT_W-1:0]   w_stepTens;
    logic [DIGIT_W-1:0]   w_stepOnes;
    logic [DIGIT_W-1:0]   w_termTens;
    logic [DIGIT_W-1:0]   w_termOnes;
    logic                 w_atTerminal;
    logic                 w_stepAtTerminal;

    key_edge u_keyStart (
        .clk_out (clk_out),
        .rst     (rst),
        .i_key_n (key_start_n),
        .o_press (w_startPress)
    );

    key_edge u_keyClear (
        .clk_out (clk_out),
        .rst     (rst),
        .i_key_n (key_clear_n),
        .o_press (w_clearPress)
    );

    // Load value follows the live mode pin; the preset is clamped per digit, then to the limit.
    always_comb begin
        w_presetTens = clampDigit(preset_tens);
        w_presetOnes = clampDigit(preset_ones);
        w_loadTens   = '0;
        w_loadOnes   = '0;
        if (mode) begin
            if (bcdValue(w_presetTens, w_presetOnes) > LIMIT) begin
                w_loadTens = LIM_TENS;
                w_loadOnes = LIM_ONES;
            end else begin
                w_loadTens = w_presetTens;
                w_loadOnes = w_presetOnes;
            end
        end
    end

    always_comb begin
        w_stepTens = r_tens;
        w_stepOnes = r_ones;
        w_termTens = r_mode ? '0 : LIM_TENS;
        w_termOnes = r_mode ? '0 : LIM_ONES;
        if (!r_mode) begin
            if (r_ones >= BCD_MAX) begin
                w_stepOnes = '0;
                if (r_tens < BCD_MAX) w_stepTens = r_tens + 4'd1;
            end else begin
                w_stepOnes = r_ones + 4'd1;
            end
        end else begin
            if (r_ones == '0) begin
                w_stepOnes = BCD_MAX;
                if (r_tens != '0) w_stepTens = r_tens - 4'd1;
            end else begin
                w_stepOnes = r_ones - 4'd1;
            end
        end
        w_atTerminal     = (r_tens == w_termTens) && (r_ones == w_termOnes);
        w_stepAtTerminal = (w_stepTens == w_termTens) && (w_stepOnes == w_termOnes);
    end

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (w_clearPress) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_startPress) w_nextState = RUN;
                RUN: begin
                    if (w_startPress)
                        w_nextState = PAUSE;
                    else if (tick && (w_atTerminal || w_stepAtTerminal))
                        w_nextState = DONE;
                end
                PAUSE:   if (w_startPress) w_nextState = RUN;
                DONE:    if (w_startPress) w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Digits, latched mode and blink divider; a start press in RUN swallows a same-cycle tick.
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            r_tens     <= '0;
            r_ones     <= '0;
            r_mode     <= 1'b0;
            r_blink    <= 1'b0;
            r_blinkCnt <= '0;
        end else if (w_clearPress || r_state == IDLE) begin
            r_tens     <= w_loadTens;
            r_ones     <= w_loadOnes;
            r_mode     <= mode;
            r_blink    <= 1'b0;
            r_blinkCnt <= '0;
        end else if (r_state == RUN) begin
            r_blink    <= 1'b0;
            r_blinkCnt <= '0;
            if (!w_startPress && tick && !w_atTerminal) begin
                r_tens <= w_stepTens;
                r_ones <= w_stepOnes;
            end
        end else if (r_state == DONE) begin
            if (w_startPress) begin
                r_blink    <= 1'b0;
                r_blinkCnt <= '0;
            end else if (tick) begin
                if (r_blinkCnt == CNT_LAST) begin
                    r_blinkCnt <= '0;
                    r_blink    <= ~r_blink;
                end else begin
                    r_blinkCnt <= r_blinkCnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        seg_data_1 = r_tens;
        seg_data_2 = r_ones;
        state      = r_state;
        done       = (r_state == DONE);
        blink      = r_blink;
    end

endmodule

// File: tb/tb_seg_timer_ctrl.sv
// Scoreboard bench: default-limit instance A and a 25-limit instance B share all stimulus.
module tb_seg_timer_ctrl;
    import seg_pkg::*;

    logic       clk_out     = 1'b0;
    logic       rst         = 1'b0;
    logic       tick        = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic       mode        = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_ones = 4'd0;

    logic [3:0] segA1, segA2, segB1, segB2;
    logic [1:0] stA, stB;
    logic       doneA, doneB, blinkA, blinkB;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [11:0] exp;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    always #5 clk_out = ~clk_out;

    seg_timer_ctrl dutA (
        .clk_out     (clk_out),
        .rst         (rst),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .mode        (mode),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .seg_data_1  (segA1),
        .seg_data_2  (segA2),
        .state       (stA),
        .done        (doneA),
        .blink       (blinkA)
    );

    seg_timer_ctrl #(.MAX_TENS(2), .MAX_ONES(5), .BLINK_DIV(4)) dutB (
        .clk_out     (clk_out),
        .rst         (rst),
        .tick        (tick),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .mode        (mode),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .seg_data_1  (segB1),
        .seg_data_2  (segB2),
        .state       (stB),
        .done        (doneB),
        .blink       (blinkB)
    );

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got {tens,ones,state,done,blink}=%h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input bit sel, input int tens, input int ones,
                              input state_t st, input bit dn, input bit bl);
        sbEntry_t e;
        e.tag = $sformatf("%s/%s", tag, sel ? "B" : "A");
        e.sel = sel;
        e.exp = {4'(tens), 4'(ones), st, dn, bl};
        sbQ.push_back(e);
    endtask

    task automatic pushBoth(input string tag, input int tens, input int ones,
                            input state_t st, input bit dn, input bit bl);
        pushExpect(tag, 1'b0, tens, ones, st, dn, bl);
        pushExpect(tag, 1'b1, tens, ones, st, dn, bl);
    endtask

    task automatic drainScoreboard();
        sbEntry_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.sel) checkOutput(e.tag, {segB1, segB2, stB, doneB, blinkB}, e.exp);
            else       checkOutput(e.tag, {segA1, segA2, stA, doneA, blinkA}, e.exp);
        end
    endtask

    // Called at a falling edge; a key press lands on the third rising edge, where doTick is also applied.
    task automatic applyStimulus(input bit doTick, input bit doStart, input bit doClear);
        if (doStart || doClear) begin
            key_start_n = ~doStart;
            key_clear_n = ~doClear;
            @(negedge clk_out);
            @(negedge clk_out);
            tick = doTick;
            @(negedge clk_out);
            tick        = 1'b0;
            key_start_n = 1'b1;
            key_clear_n = 1'b1;
            repeat (3) @(negedge clk_out);
        end else begin
            tick = doTick;
            @(negedge clk_out);
            tick = 1'b0;
        end
    endtask

    task automatic runUp(input int n, input int startVal);
        int v;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            v = startVal + i;
            pushExpect($sformatf("up%0d", v), 1'b0, v / 10, v % 10, RUN, 1'b0, 1'b0);
            if (v < 25) pushExpect($sformatf("up%0d", v), 1'b1, v / 10, v % 10, RUN, 1'b0, 1'b0);
            else        pushExpect($sformatf("up%0d", v), 1'b1, 2, 5, DONE, 1'b1, 1'(((v - 25) / 4) % 2));
            drainScoreboard();
        end
    endtask

    task automatic runDown(input int n, input int startVal);
        int v;
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            v = startVal - i;
            if (v > 0) pushBoth($sformatf("dn%0d", i), v / 10, v % 10, RUN, 1'b0, 1'b0);
            else       pushBoth($sformatf("dn%0d", i), 0, 0, DONE, 1'b1, 1'(((i - startVal) / 4) % 2));
            drainScoreboard();
        end
    endtask

    task automatic checkLoad(input int pt, input int po, input int aT, input int aO, input int bT, input int bO);
        preset_tens = 4'(pt);
        preset_ones = 4'(po);
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushExpect($sformatf("load%0h%0h", pt, po), 1'b0, aT, aO, IDLE, 1'b0, 1'b0);
        pushExpect($sformatf("load%0h%0h", pt, po), 1'b1, bT, bO, IDLE, 1'b0, 1'b0);
        drainScoreboard();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        preset_tens = 4'd7;
        preset_ones = 4'd3;
        repeat (2) @(negedge clk_out);
        pushBoth("reset", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();
        preset_tens = 4'd0;
        preset_ones = 4'd0;
        rst = 1'b1;
        repeat (4) @(negedge clk_out);

        // Up-count: A runs past 25, B stops at its 25 limit and blinks.
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("startUp", 0, 0, RUN, 1'b0, 1'b0);
        drainScoreboard();
        runUp(33, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushBoth("clear1", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();

        // Down-count from preset 10, blink in DONE, acknowledge back to IDLE.
        mode        = 1'b1;
        preset_tens = 4'd1;
        preset_ones = 4'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushBoth("idle10", 1, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("startDn", 1, 0, RUN, 1'b0, 1'b0);
        drainScoreboard();
        runDown(18, 10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("ack", 1, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();

        // Preset clamping per digit and to the limit.
        checkLoad(4'hF, 3, 9, 3, 2, 5);
        checkLoad(9, 9, 9, 9, 2, 5);
        checkLoad(2, 6, 2, 6, 2, 5);
        checkLoad(2, 4, 2, 4, 2, 4);
        checkLoad(3, 4'hF, 3, 9, 2, 5);

        // RUN entered at the down terminal: first tick enters DONE with 00.
        checkLoad(0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("startAt00", 0, 0, RUN, 1'b0, 1'b0);
        drainScoreboard();
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushBoth("termTick", 0, 0, DONE, 1'b1, 1'b0);
        drainScoreboard();
        mode = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        pushBoth("clear2", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();

        // Pause with a coincident tick, ignored ticks while paused, resume.
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("startP", 0, 0, RUN, 1'b0, 1'b0);
        drainScoreboard();
        mode = 1'b1;
        runUp(7, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pushBoth("pauseTick", 0, 7, PAUSE, 1'b0, 1'b0);
        drainScoreboard();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            pushBoth($sformatf("paused%0d", i), 0, 7, PAUSE, 1'b0, 1'b0);
            drainScoreboard();
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("resume", 0, 7, RUN, 1'b0, 1'b0);
        drainScoreboard();
        runUp(35, 7);
        mode = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushExpect("pause42", 1'b0, 4, 2, PAUSE, 1'b0, 1'b0);
        pushExpect("pause42", 1'b1, 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();
        applyStimulus(1'b0, 1'b1, 1'b1);
        pushBoth("clrStart", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();

        // Asynchronous reset mid-run with the start key held through it.
        applyStimulus(1'b0, 1'b1, 1'b0);
        runUp(5, 0);
        key_start_n = 1'b0;
        #2 rst = 1'b0;
        #1;
        pushBoth("asyncRst", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();
        @(negedge clk_out);
        @(negedge clk_out);
        rst = 1'b1;
        repeat (8) @(negedge clk_out);
        pushBoth("heldKey", 0, 0, IDLE, 1'b0, 1'b0);
        drainScoreboard();
        key_start_n = 1'b1;
        repeat (4) @(negedge clk_out);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pushBoth("repress", 0, 0, RUN, 1'b0, 1'b0);
        drainScoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
